// File: rtl/inst_fetch_unit.sv
// Fetch/sequencing stage: owns PC and IR, handshakes with instruction memory,
// and resolves the next PC from the decode controller's enables while in EXEC.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    input  logic             im_ready,
    input  logic             stall,
    input  logic             branch_ena,
    input  logic             bnez_ena,
    input  logic             Jump_ena,
    input  logic             Ret_ena,
    input  logic [31:0]      read_data1,
    input  logic [31:0]      read_data2,
    output logic [5:0]       opcode,
    output logic [4:0]       subopcode,
    output logic [3:0]       beq_typ,
    output logic [31:0]      ir,
    output logic [31:0]      pc,
    output logic             ir_valid,
    output logic [31:0]      retire_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
    } state_t;

    localparam logic [5:0] OP_BEQ  = 6'b100110;
    localparam logic [5:0] OP_BEQZ = 6'b100111;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retire_q, retire_d;

    logic [31:0] pc_seq;
    logic [31:0] off_j;
    logic [31:0] off_14;
    logic [31:0] off_16;
    logic [31:0] next_pc;

    assign im_req     = (state_q == S_FETCH);
    assign im_addr    = pc_q[IM_AW+1:2];
    assign ir_valid   = (state_q == S_EXEC);
    assign opcode     = ir_q[30:25];
    assign subopcode  = ir_q[4:0];
    assign beq_typ    = ir_q[19:16];
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign retire_cnt = retire_q;

    // Halfword-scaled offsets: sign-extend the immediate, then shift left by one.
    always_comb begin
        pc_seq  = pc_q + 32'd4;
        off_j   = {{7{ir_q[23]}}, ir_q[23:0], 1'b0};
        off_14  = {{17{ir_q[13]}}, ir_q[13:0], 1'b0};
        off_16  = {{15{ir_q[15]}}, ir_q[15:0], 1'b0};
        next_pc = pc_seq;
        if (Ret_ena) begin
            next_pc = {read_data1[31:1], 1'b0};
        end else if (Jump_ena) begin
            next_pc = pc_q + off_j;
        end else if (branch_ena && (ir_q[30:25] == OP_BEQ)) begin
            next_pc = (read_data1 == read_data2) ? (pc_q + off_14) : pc_seq;
        end else if (branch_ena && (ir_q[30:25] == OP_BEQZ)) begin
            next_pc = (read_data1 == 32'd0) ? (pc_q + off_16) : pc_seq;
        end else if (bnez_ena) begin
            next_pc = (read_data1 != 32'd0) ? (pc_q + off_16) : pc_seq;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        retire_d = retire_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (im_ready) begin
                    ir_d    = im_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_d     = next_pc;
                    retire_d = retire_q + 32'd1;
                    state_d  = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            retire_q <= retire_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed program with hand-computed PCs;
// a monitor checks every EXEC cycle against the queued expectation.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req;
    logic [9:0]  im_addr;
    logic [31:0] im_rdata;
    logic        im_ready;
    logic        stall;
    logic        branch_ena, bnez_ena, Jump_ena, Ret_ena;
    logic [31:0] read_data1, read_data2;
    logic [5:0]  opcode;
    logic [4:0]  subopcode;
    logic [3:0]  beq_typ;
    logic [31:0] ir, pc, retire_cnt;
    logic        ir_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] ret;
    } exp_t;
    exp_t exp_q[$];
    logic [31:0] exp_ret;

    localparam logic [3:0] EN_NONE = 4'b0000;
    localparam logic [3:0] EN_RET  = 4'b1000;
    localparam logic [3:0] EN_J    = 4'b0100;
    localparam logic [3:0] EN_BR   = 4'b0010;
    localparam logic [3:0] EN_BNZ  = 4'b0001;

    localparam logic [31:0] W_ADD0 = 32'h0A2B_0C21;
    localparam logic [31:0] W_ADD1 = 32'h0A2B_1C22;
    localparam logic [31:0] W_ADD2 = 32'h0A2C_0C23;
    localparam logic [31:0] W_BEQ  = 32'h4C00_3FFC;
    localparam logic [31:0] W_BEQZ = 32'h4E00_0010;
    localparam logic [31:0] W_BNEZ = 32'h5000_0010;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .IM_AW(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_rdata   (im_rdata),
        .im_ready   (im_ready),
        .stall      (stall),
        .branch_ena (branch_ena),
        .bnez_ena   (bnez_ena),
        .Jump_ena   (Jump_ena),
        .Ret_ena    (Ret_ena),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .opcode     (opcode),
        .subopcode  (subopcode),
        .beq_typ    (beq_typ),
        .ir         (ir),
        .pc         (pc),
        .ir_valid   (ir_valid),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: retiring EXEC cycles pop the scoreboard; stalled cycles must match the head unchanged.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && ir_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_exec", 32'd1, 32'd0);
                end else begin
                    e = (stall === 1'b1) ? exp_q[0] : exp_q.pop_front();
                    chk(stall ? "stall_pc" : "exec_pc", pc, e.pc);
                    chk(stall ? "stall_ir" : "exec_ir", ir, e.word);
                    chk(stall ? "stall_retire" : "exec_retire", retire_cnt, e.ret);
                    chk("opcode", 32'(opcode), 32'(e.word[30:25]));
                    chk("subopcode", 32'(subopcode), 32'(e.word[4:0]));
                    chk("beq_typ", 32'(beq_typ), 32'(e.word[19:16]));
                end
            end
        end
    end

    task automatic wait_fetch(input logic [31:0] exp_pc);
        int n = 0;
        @(negedge clk);
        while (im_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", 32'(im_req), 32'd1);
        chk("im_addr", 32'(im_addr), 32'(exp_pc[11:2]));
    endtask

    task automatic run_instr(input logic [31:0] word, input int lat, input int nstall,
                             input logic [3:0] en, input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] exp_pc);
        exp_t e;
        e.pc = exp_pc; e.word = word; e.ret = exp_ret;
        exp_q.push_back(e);
        wait_fetch(exp_pc);
        repeat (lat) begin
            @(posedge clk); #1;
            im_ready = 1'b0;
            @(negedge clk);
            chk("wait_req_held", 32'(im_req), 32'd1);
            chk("wait_addr_held", 32'(im_addr), 32'(exp_pc[11:2]));
        end
        @(posedge clk); #1;
        im_ready = 1'b1;
        im_rdata = word;
        @(posedge clk); #1;
        im_ready = 1'b0;
        im_rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
        {Ret_ena, Jump_ena, branch_ena, bnez_ena} = en;
        read_data1 = rd1;
        read_data2 = rd2;
        stall = (nstall > 0);
        repeat (nstall) begin
            im_ready = 1'b1;
            @(negedge clk);
            chk("stall_ir_valid", 32'(ir_valid), 32'd1);
            @(posedge clk); #1;
        end
        im_ready = 1'b0;
        stall = 1'b0;
        @(posedge clk); #1;
        {Ret_ena, Jump_ena, branch_ena, bnez_ena} = EN_NONE;
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, pc, 32'h0000_0000);
        chk({tag, "_ir"}, ir, 32'h0);
        chk({tag, "_retire"}, retire_cnt, 32'h0);
        chk({tag, "_im_req"}, 32'(im_req), 32'd0);
        chk({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        chk({tag, "_fields"}, {17'd0, opcode, subopcode, beq_typ}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; im_ready = 1'b0; im_rdata = '0; stall = 1'b0;
        {Ret_ena, Jump_ena, branch_ena, bnez_ena} = EN_NONE;
        read_data1 = '0; read_data2 = '0;
        exp_ret = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 32'(im_req), 32'd0);

        run_instr(W_ADD0,      1, 0, EN_NONE,      32'd0,  32'd0, 32'h0000_0000);
        run_instr(W_ADD1,      1, 0, EN_NONE,      32'd0,  32'd0, 32'h0000_0004);
        run_instr(W_ADD2,      1, 0, EN_NONE,      32'd0,  32'd0, 32'h0000_0008);
        run_instr(32'h0000_000A, 1, 0, EN_J,       32'd0,  32'd0, 32'h0000_000C);
        run_instr(W_BEQ,       1, 0, EN_BR,        32'd5,  32'd5, 32'h0000_0020);
        run_instr(32'h0000_0004, 1, 0, EN_J,       32'd0,  32'd0, 32'h0000_0018);
        run_instr(W_BEQ,       1, 0, EN_BR,        32'd5,  32'd6, 32'h0000_0020);
        run_instr(32'h0000_000E, 1, 0, EN_J,       32'd0,  32'd0, 32'h0000_0024);
        run_instr(W_BEQZ,      1, 0, EN_BR,        32'd0,  32'd1, 32'h0000_0040);
        run_instr(32'h00FF_FFF0, 1, 0, EN_J,       32'd0,  32'd0, 32'h0000_0060);
        run_instr(W_BNEZ,      1, 0, EN_BNZ,       32'd0,  32'd0, 32'h0000_0040);
        run_instr(32'h00FF_FFFE, 1, 0, EN_J,       32'd0,  32'd0, 32'h0000_0044);
        run_instr(W_BNEZ,      1, 0, EN_BNZ,       32'd7,  32'd0, 32'h0000_0040);
        run_instr(32'h0000_0050, 1, 0, EN_J,       32'd0,  32'd0, 32'h0000_0060);
        run_instr(32'h0000_0080, 3, 2, EN_J,       32'd0,  32'd0, 32'h0000_0100);
        run_instr(32'h0000_0080, 1, 0, EN_RET | EN_J, 32'h35, 32'd0, 32'h0000_0200);
        run_instr(W_ADD0,      1, 0, EN_BR,        32'd0,  32'd0, 32'h0000_0034);

        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        exp_ret = 32'hFFFF_FFFF;
        run_instr(W_ADD1,      1, 0, EN_NONE,      32'd0,  32'd0, 32'h0000_0038);
        @(negedge clk);
        chk("retire_wrap", retire_cnt, 32'h0);
        chk("pc_after_wrap", pc, 32'h0000_003C);

        // Reset in FETCH while memory answers: IR must not load.
        @(posedge clk); #1;
        rst = 1'b0;
        im_ready = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        im_ready = 1'b0;
        @(negedge clk);
        chk_reset_state("rst_fetch");
        @(posedge clk); #1;
        rst = 1'b1;
        exp_ret = '0;

        // Reset in EXEC while a jump is requested: no redirect.
        wait_fetch(32'h0000_0000);
        @(posedge clk); #1;
        im_ready = 1'b1;
        im_rdata = 32'h0000_0080;
        @(posedge clk); #1;
        im_ready = 1'b0;
        rst = 1'b0;
        Jump_ena = 1'b1;
        @(posedge clk); #1;
        Jump_ena = 1'b0;
        @(negedge clk);
        chk_reset_state("rst_exec");
        @(posedge clk); #1;
        rst = 1'b1;

        run_instr(W_ADD2,      1, 0, EN_NONE,      32'd0,  32'd0, 32'h0000_0000);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch/sequencing stage that sits directly upstream of the instruction decode controller.
- Holds the PC and instruction register (IR), and handshakes with instruction memory.
- Presents opcode, subopcode and beq_typ fields to the controller for one EXEC window per instruction.
- Uses the controller's branch_ena, bnez_ena, Jump_ena and Ret_ena, plus the register-file read data, to resolve the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- IM_AW, 10, instruction-memory word-address width; im_addr = pc[IM_AW+1:2].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low.
- im_req  output  1  instruction memory read request.
- im_addr  output  IM_AW  instruction memory word address.
- im_rdata  input  32  instruction memory read data; valid when im_ready=1.
- im_ready  input  1  instruction memory read-complete strobe.
- stall  input  1  hold current instruction in EXEC (data-memory wait).
- branch_ena  input  1  from controller: BEQ / BEQZ.
- bnez_ena  input  1  from controller: BNEZ.
- Jump_ena  input  1  from controller: J / RET.
- Ret_ena  input  1  from controller: RET.
- read_data1  input  32  register-file port 1 data.
- read_data2  input  32  register-file port 2 data.
- opcode  output  6  IR[30:25].
- subopcode  output  5  IR[4:0].
- beq_typ  output  4  IR[19:16].
- ir  output  32  full instruction register, for the immediate extender and register addressing.
- pc  output  32  current instruction byte address.
- ir_valid  output  1  high during EXEC; the controller's outputs are meaningful only then.
- retire_cnt  output  32  count of completed instructions.

Behaviour:
- Reset (rst=0 at a clk edge) takes priority over everything, including mid-fetch and EXEC.
  - Reset values: pc=RESET_PC, ir=0, state=IDLE, retire_cnt=0.
  - Derived outputs during reset: im_req=0, ir_valid=0, opcode/subopcode/beq_typ=0.
- FSM states are IDLE, FETCH and EXEC.
  - IDLE -> FETCH unconditionally on the next cycle after reset is released.
  - FETCH:
    - im_req=1 and im_addr=pc[IM_AW+1:2], both held stable until im_ready.
    - On im_ready=1: ir<=im_rdata, go to EXEC.
    - im_ready while not in FETCH is ignored.
  - EXEC:
    - ir_valid=1; opcode/subopcode/beq_typ are driven combinationally from ir.
    - If stall=1: remain in EXEC with pc, ir and retire_cnt unchanged.
    - If stall=0: pc<=next_pc, retire_cnt<=retire_cnt+1 (wraps at 2^32), go to FETCH.
- Minimum instruction period is 2 cycles (one FETCH cycle with im_ready, then one EXEC cycle).
- next_pc is evaluated in EXEC; the first matching rule applies:
  1. Ret_ena=1: {read_data1[31:1],1'b0}.
  2. Jump_ena=1 (J): pc + (sext(ir[23:0])<<1).
  3. branch_ena=1 with opcode 6'b100110 (BEQ): if read_data1==read_data2 then pc + (sext(ir[13:0])<<1), else pc+4.
  4. branch_ena=1 with opcode 6'b100111 (BEQZ): if read_data1==0 then pc + (sext(ir[15:0])<<1), else pc+4.
  5. bnez_ena=1: if read_data1!=0 then pc + (sext(ir[15:0])<<1), else pc+4.
  6. Otherwise: pc+4.
- All PC adds are 32-bit modulo 2^32, with no overflow flag. A taken target with bit0 set is impossible by construction.
- Simultaneous enables resolve by the priority order above. Enable inputs are ignored outside EXEC.
- ir_valid is never high in IDLE or FETCH. The controller output is undefined during those states and must not be consumed downstream.

Test Plan:
- Reset then sequential fetch: RESET_PC=0; memory words 0..2 hold ADD instructions; im_ready after 1 cycle -> im_addr 0,1,2 in order; pc 0,4,8; retire_cnt=3 after the third EXEC.
- BEQ taken: pc=0x20, ir imm14=14'h3FFC (-4), branch_ena=1, read_data1=read_data2=5 -> next pc=0x18. Same instruction with read_data2=6 -> next pc=0x24.
- BEQZ/BNEZ: pc=0x40, imm16=0x0010. BEQZ with read_data1=0 -> 0x60. BNEZ with read_data1=0 -> 0x44. BNEZ with read_data1=7 -> 0x60.
- J and RET: J at pc=0x100 with imm24=0x000080 -> 0x200. RET with Ret_ena=Jump_ena=1 and read_data1=0x0000_0035 -> 0x34 (the RET rule wins over the J rule).
- Stall and memory wait: im_ready withheld 3 cycles -> im_req/im_addr held stable. stall=1 for 2 EXEC cycles -> pc, ir, retire_cnt frozen and ir_valid stays 1.
- Reset mid-operation: assert rst=0 during FETCH with im_ready=1, and again in EXEC with Jump_ena=1 -> at the next edge pc=RESET_PC, ir=0, retire_cnt=0, IR not loaded, no redirect taken. Wrap check: preload retire_cnt=32'hFFFF_FFFF via force, retire one instruction -> 0.
